ex_stage: RTL

EX_STAGE -- requirements
Module: ex_stage

---
 rtl/mips_pkg.sv | 35 +++
 rtl/multu_seq.sv | 92 +++++++++
 rtl/ex_stage.sv | 118 +++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS EX-stage definitions: widths, ALU op / funct encodings,
// MEM control payload and multiplier FSM states.
package mips_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_W  = 5;
  localparam int unsigned WB_W   = 2;
  localparam int unsigned CNT_W  = 5;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_RTYPE = 2'b10;

  localparam logic [5:0] F_ADD   = 6'h20;
  localparam logic [5:0] F_SUB   = 6'h22;
  localparam logic [5:0] F_AND   = 6'h24;
  localparam logic [5:0] F_OR    = 6'h25;
  localparam logic [5:0] F_SLT   = 6'h2A;
  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MULTU = 6'h19;

  typedef enum logic [1:0] {
    MUL_IDLE = 2'd0,
    MUL_BUSY = 2'd1,
    MUL_DONE = 2'd2
  } mul_state_e;

  typedef struct packed {
    logic branch;
    logic mem_read;
    logic mem_write;
  } m_ctl_t;

endpackage

// File: rtl/multu_seq.sv
// Iterative 32x32 unsigned shift-add multiplier owning the HI/LO registers.
// Takes 1 capture cycle + 32 step cycles, then a one-cycle DONE.
module multu_seq
  import mips_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo,
  output logic            stall_c,
  output logic            done_c
);

  mul_state_e            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [2*XLEN-1:0]     mcand_q, mcand_d;
  logic [XLEN-1:0]       mplier_q, mplier_d;
  logic [2*XLEN-1:0]     prod_q, prod_d;
  logic [2*XLEN-1:0]     step_prod;
  logic [XLEN-1:0]       hi_q, hi_d, lo_q, lo_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= MUL_IDLE;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      prod_q   <= prod_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    prod_d    = prod_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    stall_c   = 1'b0;
    done_c    = 1'b0;
    step_prod = prod_q + (mplier_q[0] ? mcand_q : '0);
    case (state_q)
      MUL_IDLE: begin
        if (start) begin
          stall_c  = 1'b1;
          mcand_d  = {{XLEN{1'b0}}, op_a};
          mplier_d = op_b;
          prod_d   = '0;
          cnt_d    = '0;
          state_d  = MUL_BUSY;
        end
      end
      MUL_BUSY: begin
        stall_c  = 1'b1;
        prod_d   = step_prod;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CNT_W'(1);
        // HI/LO are only ever written on the final step
        if (cnt_q == CNT_W'(31)) begin
          hi_d    = step_prod[2*XLEN-1:XLEN];
          lo_d    = step_prod[XLEN-1:0];
          state_d = MUL_DONE;
        end
      end
      MUL_DONE: begin
        done_c  = 1'b1;
        state_d = MUL_IDLE;
      end
      default: state_d = MUL_IDLE;
    endcase
    if (rst) stall_c = 1'b0;
  end

  assign hi = hi_q;
  assign lo = lo_q;

endmodule

// File: rtl/ex_stage.sv
// MIPS execute stage: ALU, operand/destination muxes, branch target and
// EX/MEM pipeline registers; MULTU is delegated to multu_seq.
module ex_stage
  import mips_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [WB_W-1:0]     wb_ctl_in,
  input  logic [2:0]          m_ctl_in,
  input  logic [1:0]          alu_op,
  input  logic                alu_src,
  input  logic                reg_dst,
  input  logic [XLEN-1:0]     npc,
  input  logic [XLEN-1:0]     read_data1,
  input  logic [XLEN-1:0]     read_data2,
  input  logic [XLEN-1:0]     sign_ext,
  input  logic [REG_W-1:0]    rt,
  input  logic [REG_W-1:0]    rd,
  output logic [WB_W-1:0]     ex_wb_ctl,
  output logic                ex_branch,
  output logic                ex_mem_read,
  output logic                ex_mem_write,
  output logic                ex_zero,
  output logic [XLEN-1:0]     ex_alu_result,
  output logic [XLEN-1:0]     ex_write_data,
  output logic [XLEN-1:0]     ex_branch_target,
  output logic [REG_W-1:0]    ex_write_reg,
  output logic                stall
);

  m_ctl_t            m_ctl;
  logic [5:0]        funct;
  logic [XLEN-1:0]   op_b;
  logic [XLEN-1:0]   alu_res;
  logic [XLEN-1:0]   br_target;
  logic [REG_W-1:0]  write_reg;
  logic [XLEN-1:0]   hi, lo;
  logic              mul_start;
  logic              mul_stall;
  logic              mul_done;
  logic              bubble;
  logic              slt_res;

  assign m_ctl     = m_ctl_t'(m_ctl_in);
  assign funct     = sign_ext[5:0];
  assign op_b      = alu_src ? sign_ext : read_data2;
  assign mul_start = (alu_op == ALU_RTYPE) && (funct == F_MULTU);
  assign br_target = npc + (sign_ext << 2);
  assign write_reg = reg_dst ? rd : rt;
  assign slt_res   = $signed(read_data1) < $signed(op_b);

  multu_seq u_multu (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_start),
    .op_a    (read_data1),
    .op_b    (read_data2),
    .hi      (hi),
    .lo      (lo),
    .stall_c (mul_stall),
    .done_c  (mul_done)
  );

  assign stall  = mul_stall;
  assign bubble = mul_stall | mul_done;

  always_comb begin
    alu_res = '0;
    case (alu_op)
      ALU_ADD: alu_res = read_data1 + op_b;
      ALU_SUB: alu_res = read_data1 - op_b;
      ALU_RTYPE: begin
        case (funct)
          F_ADD:   alu_res = read_data1 + op_b;
          F_SUB:   alu_res = read_data1 - op_b;
          F_AND:   alu_res = read_data1 & op_b;
          F_OR:    alu_res = read_data1 | op_b;
          F_SLT:   alu_res = {{(XLEN-1){1'b0}}, slt_res};
          F_MFHI:  alu_res = hi;
          F_MFLO:  alu_res = lo;
          default: alu_res = '0;
        endcase
      end
      default: alu_res = '0;
    endcase
  end

  // Bubbles zero the control fields but leave the data fields untouched
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_wb_ctl        <= '0;
      ex_branch        <= 1'b0;
      ex_mem_read      <= 1'b0;
      ex_mem_write     <= 1'b0;
      ex_zero          <= 1'b0;
      ex_alu_result    <= '0;
      ex_write_data    <= '0;
      ex_branch_target <= '0;
      ex_write_reg     <= '0;
    end else if (bubble) begin
      ex_wb_ctl        <= '0;
      ex_branch        <= 1'b0;
      ex_mem_read      <= 1'b0;
      ex_mem_write     <= 1'b0;
    end else begin
      ex_wb_ctl        <= wb_ctl_in;
      ex_branch        <= m_ctl.branch;
      ex_mem_read      <= m_ctl.mem_read;
      ex_mem_write     <= m_ctl.mem_write;
      ex_zero          <= (alu_res == '0);
      ex_alu_result    <= alu_res;
      ex_write_data    <= read_data2;
      ex_branch_target <= br_target;
      ex_write_reg     <= write_reg;
    end
  end

endmodule
